// File: rtl/dms_tx.sv
// Serial transmitter for the decryption-message-system line: key configuration
// (mode=1) then pulse-width encoded message bits (mode=0). Define DMS_TX_PARITY_EN
// to append an even-parity period after the last message bit.
module dms_tx #(
  parameter int MAX_N  = 5,
  parameter int MSG_W  = 16,
  parameter int PERIOD = 16,
  parameter int ONES_1 = 12,
  parameter int ONES_0 = 4,
  localparam int KW = 2**MAX_N,
  localparam int LW = $clog2(MSG_W+1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [3:0]    cfg_n,
  input  logic [KW-1:0] cfg_d,
  input  logic [KW-1:0] cfg_caps,
  input  logic [MSG_W-1:0] msg,
  input  logic [LW-1:0] len,
  output logic          str,
  output logic          mode,
  output logic          busy,
  output logic          done,
  output logic          err
);
  localparam int PW = $clog2(PERIOD);
  localparam int BW = (MSG_W > 1) ? $clog2(MSG_W) : 1;
  localparam logic [PW-1:0] P_LAST  = PW'(PERIOD-1);
  localparam logic [PW-1:0] O1      = PW'(ONES_1);
  localparam logic [PW-1:0] O0      = PW'(ONES_0);
  localparam logic [LW-1:0] LEN_MAX = LW'(MSG_W);
  localparam logic [3:0]    N_MAX   = 4'(MAX_N);

  typedef enum logic [3:0] {
    S_IDLE, S_CFG_N, S_CFG_D, S_CFG_C, S_CFG_G, S_PRE, S_DATA, S_PAR, S_TERM
  } state_t;

`ifdef DMS_TX_PARITY_EN
  localparam state_t S_AFTER = S_PAR;
`else
  localparam state_t S_AFTER = S_TERM;
`endif

  state_t state_q, state_d;
  logic [MAX_N-1:0] cidx_q, cidx_d;
  logic [PW-1:0]    pcnt_q, pcnt_d;
  logic [BW-1:0]    bidx_q, bidx_d;
  logic [3:0]       n_q, n_d;
  logic [KW-1:0]    d_q, d_d, c_q, c_d;
  logic [MSG_W-1:0] msg_q, msg_d;
  logic [LW-1:0]    len_q, len_d;
  logic             done_q, done_d, err_q, err_d;
  logic [MAX_N-1:0] key_top;
  logic             period_end, cur_bit;
  logic [PW-1:0]    ones;

`ifdef DMS_TX_PARITY_EN
  logic par_q, par_d, par_calc;

  always_comb begin
    par_calc = 1'b0;
    for (int i = 0; i < MSG_W; i++)
      if (LW'(i) < len) par_calc = par_calc ^ msg[i];
  end
`endif

  assign key_top    = MAX_N'((KW'(1) << n_q) - KW'(1));
  assign period_end = (pcnt_q == P_LAST);

  always_comb begin
    cur_bit = 1'b0;
    case (state_q)
      S_DATA:  cur_bit = msg_q[bidx_q];
`ifdef DMS_TX_PARITY_EN
      S_PAR:   cur_bit = par_q;
`endif
      default: cur_bit = 1'b0;
    endcase
  end

  assign ones = cur_bit ? O1 : O0;

  // Line output is a pure decode of the state and counters.
  always_comb begin
    str  = 1'b0;
    mode = 1'b0;
    case (state_q)
      S_CFG_N: begin mode = 1'b1; str = n_q[cidx_q[1:0]]; end
      S_CFG_D: begin mode = 1'b1; str = d_q[cidx_q]; end
      S_CFG_C: begin mode = 1'b1; str = c_q[cidx_q]; end
      S_CFG_G: mode = 1'b1;
      S_PRE, S_DATA, S_PAR: str = (pcnt_q < ones);
      S_TERM:  str = 1'b1;
      default: ;
    endcase
  end

  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign err  = err_q;

  always_comb begin
    state_d = state_q;
    cidx_d  = cidx_q;
    pcnt_d  = pcnt_q;
    bidx_d  = bidx_q;
    n_d     = n_q;
    d_d     = d_q;
    c_d     = c_q;
    msg_d   = msg_q;
    len_d   = len_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
`ifdef DMS_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      S_IDLE: if (start) begin
        if (cfg_n > N_MAX || len > LEN_MAX) begin
          err_d = 1'b1;
        end else begin
          n_d     = cfg_n;
          d_d     = cfg_d;
          c_d     = cfg_caps;
          msg_d   = msg;
          len_d   = len;
          cidx_d  = MAX_N'(3);
          pcnt_d  = '0;
          bidx_d  = '0;
          state_d = S_CFG_N;
`ifdef DMS_TX_PARITY_EN
          par_d   = par_calc;
`endif
        end
      end
      S_CFG_N: if (cidx_q == '0) begin
        cidx_d = key_top; state_d = S_CFG_D;
      end else cidx_d = cidx_q - 1'b1;
      S_CFG_D: if (cidx_q == '0) begin
        cidx_d = key_top; state_d = S_CFG_C;
      end else cidx_d = cidx_q - 1'b1;
      S_CFG_C: if (cidx_q == '0) state_d = S_CFG_G;
               else cidx_d = cidx_q - 1'b1;
      S_CFG_G: begin pcnt_d = '0; state_d = S_PRE; end
      S_PRE: if (period_end) begin
        pcnt_d = '0;
        if (len_q == '0) state_d = S_AFTER;
        else begin
          bidx_d  = BW'(len_q - LW'(1));
          state_d = S_DATA;
        end
      end else pcnt_d = pcnt_q + 1'b1;
      S_DATA: if (period_end) begin
        pcnt_d = '0;
        if (bidx_q == '0) state_d = S_AFTER;
        else bidx_d = bidx_q - 1'b1;
      end else pcnt_d = pcnt_q + 1'b1;
      S_PAR: if (period_end) begin
        pcnt_d = '0; state_d = S_TERM;
      end else pcnt_d = pcnt_q + 1'b1;
      S_TERM: begin done_d = 1'b1; state_d = S_IDLE; end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cidx_q  <= '0;
      pcnt_q  <= '0;
      bidx_q  <= '0;
      n_q     <= '0;
      d_q     <= '0;
      c_q     <= '0;
      msg_q   <= '0;
      len_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef DMS_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cidx_q  <= cidx_d;
      pcnt_q  <= pcnt_d;
      bidx_q  <= bidx_d;
      n_q     <= n_d;
      d_q     <= d_d;
      c_q     <= c_d;
      msg_q   <= msg_d;
      len_q   <= len_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef DMS_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end
endmodule

// File: tb/tb_dms_tx.sv
// Directed-vector bench for dms_tx: each vector's line waveform is rebuilt from the
// protocol description and compared cycle by cycle, with hand-computed frame lengths.
module tb_dms_tx;
`ifdef DMS_TX_PARITY_EN
  localparam int PX = 16;
`else
  localparam int PX = 0;
`endif

  logic clk = 1'b0;
  logic reset, start;
  logic [3:0]  cfg_n;
  logic [31:0] cfg_d, cfg_caps;
  logic [15:0] msg;
  logic [4:0]  len;
  logic str, mode, busy, done, err;

  dms_tx dut (
    .clk(clk), .reset(reset), .start(start), .cfg_n(cfg_n), .cfg_d(cfg_d),
    .cfg_caps(cfg_caps), .msg(msg), .len(len), .str(str), .mode(mode),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  n;
    logic [31:0] d;
    logic [31:0] c;
    logic [15:0] msg;
    logic [4:0]  len;
    logic        exp_err;
    int          exp_done;
  } vec_t;

  vec_t vt[8];
  int checks = 0;
  int failures = 0;
  logic cap_str[1024], cap_mode[1024], cap_busy[1024], cap_done[1024], cap_err[1024];
  logic es[$];
  logic em[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic s, input logic m);
    es.push_back(s);
    em.push_back(m);
  endtask

  task automatic period(input logic b);
    int o;
    o = b ? 12 : 4;
    for (int p = 0; p < 16; p++) push(p < o, 1'b0);
  endtask

  task automatic build_model(input vec_t v);
    int kw;
    logic p;
    es.delete();
    em.delete();
    kw = 1 << v.n;
    for (int i = 3; i >= 0; i--) push(v.n[i], 1'b1);
    for (int i = kw-1; i >= 0; i--) push(v.d[i], 1'b1);
    for (int i = kw-1; i >= 0; i--) push(v.c[i], 1'b1);
    push(1'b0, 1'b1);
    period(1'b0);
    p = 1'b0;
    for (int k = int'(v.len) - 1; k >= 0; k--) begin
      period(v.msg[k]);
      p = p ^ v.msg[k];
    end
`ifdef DMS_TX_PARITY_EN
    period(p);
`endif
    push(1'b1, 1'b0);
  endtask

  // Drives one start, records ncyc cycles; when poke is set, a second start with
  // illegal/scrambled inputs is issued mid-transfer.
  task automatic run_capture(input vec_t v, input int ncyc, input bit poke);
    @(negedge clk);
    cfg_n = v.n; cfg_d = v.d; cfg_caps = v.c; msg = v.msg; len = v.len;
    start = 1'b1;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      cap_str[k] = str; cap_mode[k] = mode; cap_busy[k] = busy;
      cap_done[k] = done; cap_err[k] = err;
      if (k == 1) start = 1'b0;
      if (poke && k == 2) begin
        cfg_n = 4'd7; cfg_d = ~v.d; cfg_caps = ~v.c; msg = ~v.msg; len = 5'd31;
      end
      if (poke && k == 10) start = 1'b1;
      if (poke && k == 11) start = 1'b0;
    end
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    int ncyc, dcyc, dcnt, ecnt, wbad, bbad, sm;
    v = vt[i];
    ncyc = v.exp_err ? 4 : v.exp_done + 3;
    run_capture(v, ncyc, !v.exp_err);
    dcyc = -1; dcnt = 0; ecnt = 0; sm = 0; bbad = 0; wbad = 0;
    for (int k = 1; k <= ncyc; k++) begin
      if (cap_done[k]) begin dcnt++; if (dcyc < 0) dcyc = k; end
      if (cap_err[k]) ecnt++;
      if (cap_busy[k]) bbad++;
      if (cap_str[k] || cap_mode[k]) sm++;
    end
    if (v.exp_err) begin
      chk($sformatf("v%0d_err_pulse", i), {63'd0, cap_err[1]}, 64'd1);
      chk($sformatf("v%0d_err_count", i), 64'(ecnt), 64'd1);
      chk($sformatf("v%0d_idle_busy", i), 64'(bbad), 64'd0);
      chk($sformatf("v%0d_idle_line", i), 64'(sm), 64'd0);
    end else begin
      build_model(v);
      bbad = 0;
      for (int k = 1; k <= es.size(); k++) begin
        if (cap_str[k] !== es[k-1] || cap_mode[k] !== em[k-1]) wbad++;
        if (cap_busy[k] !== 1'b1) bbad++;
      end
      if (cap_busy[v.exp_done] !== 1'b0) bbad++;
      chk($sformatf("v%0d_done_cycle", i), 64'(dcyc), 64'(v.exp_done));
      chk($sformatf("v%0d_wave_bad", i), 64'(wbad), 64'd0);
      chk($sformatf("v%0d_busy_bad", i), 64'(bbad), 64'd0);
      chk($sformatf("v%0d_done_count", i), 64'(dcnt), 64'd1);
      chk($sformatf("v%0d_err_count", i), 64'(ecnt), 64'd0);
    end
  endtask

  initial begin
    logic [12:0] cfg_seq;
    int pre_ones;
    vt[0] = '{4'd2, 32'hA,        32'h1,        16'h0,    5'd0,  1'b0, 31 + PX};
    vt[1] = '{4'd2, 32'hA,        32'h1,        16'h5,    5'd3,  1'b0, 79 + PX};
    vt[2] = '{4'd6, 32'hA,        32'h1,        16'h5,    5'd3,  1'b1, 0};
    vt[3] = '{4'd2, 32'hA,        32'h1,        16'h5,    5'd17, 1'b1, 0};
    vt[4] = '{4'd5, 32'hDEADBEEF, 32'h0F0F1234, 16'hA5C3, 5'd16, 1'b0, 343 + PX};
    vt[5] = '{4'd0, 32'h1,        32'h0,        16'h1,    5'd1,  1'b0, 41 + PX};
    vt[6] = '{4'd3, 32'h5A,       32'h81,       16'h7,    5'd3,  1'b0, 87 + PX};
    vt[7] = '{4'd1, 32'h2,        32'h3,        16'h0,    5'd1,  1'b0, 43 + PX};

    reset = 1'b1; start = 1'b0; cfg_n = '0; cfg_d = '0; cfg_caps = '0; msg = '0; len = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {59'd0, str, mode, busy, done, err}, 64'd0);
    reset = 1'b0;

    run_vec(0);
    for (int k = 1; k <= 13; k++) cfg_seq[13-k] = cap_str[k];
    chk("v0_cfg_bits", 64'(cfg_seq), 64'(13'b0010_1010_0001_0));
    pre_ones = 0;
    for (int k = 14; k <= 29; k++) if (cap_str[k]) pre_ones++;
    chk("v0_pre_ones", 64'(pre_ones), 64'd4);
    chk("v0_term", {63'd0, cap_str[30 + PX]}, 64'd1);

    for (int i = 1; i < 8; i++) run_vec(i);

    // Reset in the middle of CFG_D (cycles 5..12 at n=3).
    @(negedge clk);
    cfg_n = 4'd3; cfg_d = 32'h5A; cfg_caps = 32'h81; msg = 16'h7; len = 5'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    chk("mid_reset_busy_before", {63'd0, busy}, 64'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_reset_outputs", {59'd0, str, mode, busy, done, err}, 64'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("after_reset_outputs", {59'd0, str, mode, busy, done, err}, 64'd0);
    run_vec(6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
